// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory sequencer: program load into IMEM, then PC fetch with stall/branch/halt.
// Optional build macro IMEM_LOAD_CHECKSUM_EN adds a load checksum output and expected-value check.
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  output logic              load_ready,
  input  logic              load_last,
  input  logic              run_en,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W-1:0] imem_raddr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       pc,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              halted,
  output logic              fault,
  output logic [ADDR_W:0]   load_count
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]       load_csum,
  input  logic [31:0]       load_csum_exp
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // First byte address past the end of instruction memory.
  localparam logic [32:0] PC_LIMIT = 33'd4 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_r, state_n;
  logic [31:0]       pc_r, pc_n;
  logic [ADDR_W:0]   load_count_r, count_n;
  logic              fault_r, fault_n;
  logic              accept_s;
  logic              run_s;
  logic [32:0]       pc_inc_s;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]       csum_r, csum_n, csum_sum_s;
`endif

  assign run_s       = (state_r == ST_RUN);
  // The top count bit doubles as the memory-full flag.
  assign load_ready  = (state_r == ST_LOAD) && !load_count_r[ADDR_W];
  assign accept_s    = load_valid && load_ready;
  assign imem_we     = accept_s;
  assign imem_waddr  = accept_s ? load_count_r[ADDR_W-1:0] : {ADDR_W{1'b0}};
  assign imem_wdata  = accept_s ? load_data : 32'h0;
  assign imem_raddr  = run_s ? pc_r[ADDR_W+1:2] : {ADDR_W{1'b0}};
  assign instr       = run_s ? imem_rdata : 32'h0;
  assign instr_valid = run_s && !stall;
  assign halted      = (state_r == ST_HALT);
  assign pc          = pc_r;
  assign fault       = fault_r;
  assign load_count  = load_count_r;
  assign pc_inc_s    = {1'b0, pc_r} + 33'd4;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign load_csum   = csum_r;
  assign csum_sum_s  = csum_r + load_data;
`endif

  // Next-state and next-value logic for the load/run sequencer.
  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    count_n = load_count_r;
    fault_n = fault_r;
`ifdef IMEM_LOAD_CHECKSUM_EN
    csum_n  = csum_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (load_start) begin
          state_n = ST_LOAD;
          count_n = {(ADDR_W+1){1'b0}};
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_n  = 32'h0;
`endif
        end else if (run_en) begin
          state_n = ST_RUN;
          pc_n    = RESET_PC;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          count_n = load_count_r + CNT_ONE;
`ifdef IMEM_LOAD_CHECKSUM_EN
          csum_n  = csum_sum_s;
          if (load_last && (csum_sum_s != load_csum_exp)) begin
            state_n = ST_HALT;
            fault_n = 1'b1;
          end else if (load_last) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_LOAD;
          end
`else
          if (load_last) begin
            state_n = ST_IDLE;
          end else begin
            state_n = ST_LOAD;
          end
`endif
        end else if (load_count_r[ADDR_W]) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_LOAD;
        end
      end
      ST_RUN: begin
        // Stall wins over everything; a zero word means unprogrammed memory.
        if (stall) begin
          state_n = ST_RUN;
        end else if (imem_rdata == 32'h0) begin
          state_n = ST_HALT;
        end else if (branch_taken) begin
          if ((branch_target[1:0] != 2'b00) || ({1'b0, branch_target} >= PC_LIMIT)) begin
            state_n = ST_HALT;
            fault_n = 1'b1;
          end else begin
            pc_n = branch_target;
          end
        end else if (pc_inc_s >= PC_LIMIT) begin
          state_n = ST_HALT;
        end else begin
          pc_n = pc_inc_s[31:0];
        end
      end
      ST_HALT: begin
        state_n = ST_HALT;
      end
      default: begin
        state_n = ST_IDLE;
        pc_n    = RESET_PC;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pc_r         <= RESET_PC;
      load_count_r <= {(ADDR_W+1){1'b0}};
      fault_r      <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_r       <= 32'h0;
`endif
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      load_count_r <= count_n;
      fault_r      <= fault_n;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum_r       <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized fetch vs. a reference model.
module tb_imem_fetch_ctrl;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, load_start, load_valid, load_ready, load_last, run_en, stall, branch_taken;
  logic [31:0]       load_data, branch_target, imem_wdata, imem_rdata, pc, instr;
  logic              imem_we, instr_valid, halted, fault;
  logic [ADDR_W-1:0] imem_waddr, imem_raddr;
  logic [ADDR_W:0]   load_count;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]       load_csum, load_csum_exp;
`endif

  logic [31:0] mem     [DEPTH] = '{default: 32'h0};
  logic [31:0] ref_mem [DEPTH] = '{default: 32'h0};
  logic [31:0] prog    [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;

  always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
  assign imem_rdata = mem[imem_raddr];

  imem_fetch_ctrl #(.ADDR_W(ADDR_W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_last(load_last),
    .run_en(run_en), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .halted(halted),
    .fault(fault), .load_count(load_count)
`ifdef IMEM_LOAD_CHECKSUM_EN
    , .load_csum(load_csum), .load_csum_exp(load_csum_exp)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    load_start = 1'b0; load_valid = 1'b0; load_data = 32'h0; load_last = 1'b0;
    run_en = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load_prog(input int n);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = prog[i];
      load_last  = (i == n - 1);
      ref_mem[i] = prog[i];
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0; load_data = 32'h0;
  endtask

  task automatic start_run;
    run_en = 1'b1;
    tick();
    run_en = 1'b0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    n_chk++;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected %h", pc, 32'h0); end
    n_chk++;
    if ({load_count, fault, halted, instr_valid, imem_we, load_ready} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got cnt=%0d fault=%b halted=%b valid=%b we=%b ready=%b expected all 0",
               load_count, fault, halted, instr_valid, imem_we, load_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_load;
    prog[0] = 32'h0000_0033; prog[1] = 32'h0010_0093; prog[2] = 32'h0000_0000;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_data = prog[i]; load_last = (i == 2); ref_mem[i] = prog[i];
      #1;
      n_chk++;
      if ({load_ready, imem_we, imem_waddr, imem_wdata} !== {1'b1, 1'b1, 6'(i), prog[i]}) begin
        n_fail++;
        $display("FAIL load_write[%0d]: got ready=%b we=%b addr=%0d data=%h expected 1 1 %0d %h",
                 i, load_ready, imem_we, imem_waddr, imem_wdata, i, prog[i]);
      end
      tick();
    end
    load_valid = 1'b0; load_last = 1'b0;
    #1;
    n_chk++;
    if ({load_count, load_ready, imem_we, halted} !== {7'd3, 3'b000}) begin
      n_fail++;
      $display("FAIL load_done: got cnt=%0d ready=%b we=%b halted=%b expected 3 0 0 0",
               load_count, load_ready, imem_we, halted);
    end
  endtask

  task automatic test_run;
    start_run();
    for (int k = 0; k < 3; k++) begin
      #1;
      n_chk++;
      if ({pc, instr_valid, instr} !== {32'(4 * k), 1'b1, ref_mem[k]}) begin
        n_fail++;
        $display("FAIL run_fetch[%0d]: got pc=%h valid=%b instr=%h expected %h 1 %h",
                 k, pc, instr_valid, instr, 4 * k, ref_mem[k]);
      end
      tick();
    end
    #1;
    n_chk++;
    if ({halted, pc, instr_valid, imem_we} !== {1'b1, 32'h8, 2'b00}) begin
      n_fail++;
      $display("FAIL run_halt: got halted=%b pc=%h valid=%b we=%b expected 1 00000008 0 0",
               halted, pc, instr_valid, imem_we);
    end
  endtask

  task automatic test_stall_branch;
    do_reset();
    for (int i = 0; i < 8; i++) prog[i] = 32'h1000_0013 + 32'(i);
    load_prog(8);
    start_run();
    tick();
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h10;
    #1;
    n_chk++;
    if ({instr_valid, pc} !== {1'b0, 32'h4}) begin
      n_fail++; $display("FAIL stall_valid: got valid=%b pc=%h expected 0 00000004", instr_valid, pc);
    end
    tick();
    stall = 1'b0;
    #1;
    n_chk++;
    if ({pc, instr_valid, instr} !== {32'h4, 1'b1, ref_mem[1]}) begin
      n_fail++;
      $display("FAIL stall_hold: got pc=%h valid=%b instr=%h expected 00000004 1 %h", pc, instr_valid, instr, ref_mem[1]);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    n_chk++;
    if ({pc, instr, halted} !== {32'h10, ref_mem[4], 1'b0}) begin
      n_fail++;
      $display("FAIL branch_redirect: got pc=%h instr=%h halted=%b expected 00000010 %h 0", pc, instr, halted, ref_mem[4]);
    end
  endtask

  task automatic test_fault;
    for (int t = 0; t < 2; t++) begin
      do_reset();
      #1;
      n_chk++;
      if (fault !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b expected 0", fault); end
      start_run();
      branch_taken = 1'b1;
      branch_target = (t == 0) ? 32'h102 : 32'h100;
      tick();
      branch_taken = 1'b0;
      #1;
      n_chk++;
      if ({halted, fault, pc} !== {2'b11, 32'h0}) begin
        n_fail++;
        $display("FAIL fault_target_%h: got halted=%b fault=%b pc=%h expected 1 1 00000000", branch_target, halted, fault, pc);
      end
      run_en = 1'b1; load_start = 1'b1;
      tick();
      run_en = 1'b0; load_start = 1'b0;
      #1;
      n_chk++;
      if ({halted, fault, load_ready, instr_valid} !== 4'b1100) begin
        n_fail++;
        $display("FAIL halt_sticky: got halted=%b fault=%b ready=%b valid=%b expected 1 1 0 0", halted, fault, load_ready, instr_valid);
      end
    end
  endtask

  task automatic test_overflow;
    int writes;
    writes = 0;
    do_reset();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      load_valid = 1'b1; load_data = $urandom | 32'h1; load_last = 1'b0;
      if (i < DEPTH) ref_mem[i] = load_data;
      #1;
      n_chk++;
      if (load_ready !== (i < DEPTH)) begin
        n_fail++; $display("FAIL full_ready[%0d]: got %b expected %b", i, load_ready, (i < DEPTH));
      end
      if (imem_we) begin
        writes++;
        n_chk++;
        if (imem_waddr !== 6'(i)) begin
          n_fail++; $display("FAIL full_addr[%0d]: got %0d expected %0d", i, imem_waddr, i);
        end
      end
      tick();
    end
    load_valid = 1'b0;
    #1;
    n_chk++;
    if ({load_count, load_ready} !== {7'd64, 1'b0} || writes != DEPTH) begin
      n_fail++;
      $display("FAIL full_done: got cnt=%0d ready=%b writes=%0d expected 64 0 64", load_count, load_ready, writes);
    end
  endtask

  task automatic test_end_of_mem;
    do_reset();
    start_run();
    branch_taken = 1'b1; branch_target = 32'hFC;
    tick();
    branch_taken = 1'b0;
    #1;
    n_chk++;
    if ({pc, halted, instr_valid, instr} !== {32'hFC, 1'b0, 1'b1, ref_mem[63]}) begin
      n_fail++;
      $display("FAIL last_word: got pc=%h halted=%b valid=%b instr=%h expected 000000fc 0 1 %h", pc, halted, instr_valid, instr, ref_mem[63]);
    end
    tick();
    #1;
    n_chk++;
    if ({halted, fault, pc} !== {2'b10, 32'hFC}) begin
      n_fail++; $display("FAIL end_halt: got halted=%b fault=%b pc=%h expected 1 0 000000fc", halted, fault, pc);
    end
  endtask

  task automatic test_reset_mid_load;
    do_reset();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      load_valid = 1'b1; load_data = $urandom | 32'h1; ref_mem[i] = load_data;
      tick();
    end
    load_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_chk++;
    if ({load_count, load_ready} !== 8'h00) begin
      n_fail++; $display("FAIL midload_reset: got cnt=%0d ready=%b expected 0 0", load_count, load_ready);
    end
    start_run();
    #1;
    n_chk++;
    if ({pc, instr_valid, instr} !== {32'h0, 1'b1, ref_mem[0]}) begin
      n_fail++;
      $display("FAIL midload_fetch: got pc=%h valid=%b instr=%h expected 00000000 1 %h", pc, instr_valid, instr, ref_mem[0]);
    end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, tgt;
    logic        exp_halt, exp_fault;
    int          n, sel;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(4, 24);
      for (int i = 0; i < n; i++) prog[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
      load_prog(n);
      start_run();
      exp_pc = 32'h0; exp_halt = 1'b0; exp_fault = 1'b0;
      for (int c = 0; c < 80 && !exp_halt; c++) begin
        stall = ($urandom_range(0, 3) == 0);
        branch_taken = ($urandom_range(0, 4) == 0);
        sel = $urandom_range(0, 9);
        tgt = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
        if (sel == 7) tgt = tgt | 32'($urandom_range(1, 3));
        else if (sel > 7) tgt = $urandom | 32'h100;
        branch_target = tgt;
        #1;
        n_chk++;
        if ({pc, instr_valid, halted} !== {exp_pc, !stall, 1'b0}) begin
          n_fail++;
          $display("FAIL rand_state r%0d c%0d: got pc=%h valid=%b halted=%b expected %h %b 0", r, c, pc, instr_valid, halted, exp_pc, !stall);
        end
        if (!stall) begin
          n_chk++;
          if (instr !== ref_mem[exp_pc[7:2]]) begin
            n_fail++; $display("FAIL rand_instr r%0d c%0d: got %h expected %h", r, c, instr, ref_mem[exp_pc[7:2]]);
          end
          if (ref_mem[exp_pc[7:2]] == 32'h0) exp_halt = 1'b1;
          else if (branch_taken && (tgt[1:0] != 2'b00 || tgt >= 32'd256)) begin exp_halt = 1'b1; exp_fault = 1'b1; end
          else if (branch_taken) exp_pc = tgt;
          else if (exp_pc + 32'd4 >= 32'd256) exp_halt = 1'b1;
          else exp_pc = exp_pc + 32'd4;
        end
        tick();
      end
      clear_inputs();
      #1;
      n_chk++;
      if ({halted, fault, pc} !== {exp_halt, exp_fault, exp_pc}) begin
        n_fail++;
        $display("FAIL rand_end r%0d: got halted=%b fault=%b pc=%h expected %b %b %h", r, halted, fault, pc, exp_halt, exp_fault, exp_pc);
      end
    end
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum;
    logic [31:0] sum;
    sum = 32'h0;
    for (int i = 0; i < 3; i++) begin prog[i] = $urandom | 32'h1; sum = sum + prog[i]; end
    do_reset();
    load_csum_exp = sum + 32'h1;
    load_prog(3);
    #1;
    n_chk++;
    if ({halted, fault, load_csum} !== {2'b11, sum}) begin
      n_fail++; $display("FAIL csum_bad: got halted=%b fault=%b csum=%h expected 1 1 %h", halted, fault, load_csum, sum);
    end
    do_reset();
    load_csum_exp = sum;
    load_prog(3);
    #1;
    n_chk++;
    if ({halted, fault, load_csum} !== {2'b00, sum}) begin
      n_fail++; $display("FAIL csum_good: got halted=%b fault=%b csum=%h expected 0 0 %h", halted, fault, load_csum, sum);
    end
  endtask
`endif

  initial begin
`ifdef IMEM_LOAD_CHECKSUM_EN
    load_csum_exp = 32'h0;
`endif
    test_reset();
    test_load();
    test_run();
    test_stall_branch();
    test_fault();
    test_overflow();
    test_end_of_mem();
    test_reset_mid_load();
    test_random();
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
